// File: rtl/dma_sequencer_n.sv
// N-channel DMA sequencer: arbitrates device requests onto one dma_access port, routes completions back via a tag FIFO.
// One IDLE cycle per grant; ack/done/rd are combinational; grants stall while OUTST transactions are outstanding.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_vld,
  output logic            wr_rdy,
  input  logic [W-1:0]    wr_dat,
  output logic            rd_vld,
  input  logic            rd_rdy,
  output logic [W-1:0]    rd_dat,
  output logic [CNTW-1:0] cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign wr_rdy = (cnt != CNTW'(DEPTH));
  assign rd_vld = (cnt != '0);
  assign do_wr  = wr_vld && wr_rdy;
  assign do_rd  = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= nxt(wr_ptr);
      if (do_rd) rd_ptr <= nxt(rd_ptr);
      if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
      else if (do_rd && !do_wr) cnt <= cnt - 1'b1;
    end
  end
endmodule

module dma_sequencer_n #(
  parameter int NCH   = 4,
  parameter int AW    = 21,
  parameter int DW    = 8,
  parameter int OUTST = 2,
  parameter int RR    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    rnw,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wd,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    done,
  output logic [DW-1:0]     rd,
  output logic              dma_req,
  output logic              dma_rnw,
  output logic [AW-1:0]     dma_addr,
  output logic [DW-1:0]     dma_wd,
  input  logic              dma_ack,
  input  logic              dma_end,
  input  logic [DW-1:0]     dma_rd,
  output logic [3:0]        outstanding,
  output logic              err_unf
);
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNTW = $clog2(OUTST + 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          state;
  logic [CW-1:0]   cur;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   winner;
  logic [CW-1:0]   idx;
  logic            found;
  logic [CW-1:0]   tag_head;
  logic [CNTW-1:0] tag_cnt;
  logic            tag_wr_rdy;
  logic            tag_vld;
  logic            tag_push;
  logic            grant;

  // Search order starts one past the last grant in round-robin mode, at channel 0 otherwise.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (RR != 0) idx = CW'((int'(rr_ptr) + 1 + i) % NCH);
      else         idx = CW'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign grant    = (state == S_IDLE) && found && tag_wr_rdy;
  assign tag_push = (state == S_REQ) && dma_ack;

  fifo #(.W(CW), .DEPTH(OUTST), .CNTW(CNTW)) u_tag_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (tag_push),
    .wr_rdy (tag_wr_rdy),
    .wr_dat (cur),
    .rd_vld (tag_vld),
    .rd_rdy (dma_end),
    .rd_dat (tag_head),
    .cnt    (tag_cnt)
  );

  always_comb begin
    ack  = '0;
    done = '0;
    if (tag_push)           ack[cur]       = 1'b1;
    if (dma_end && tag_vld) done[tag_head] = 1'b1;
  end

  assign rd          = dma_rd;
  assign outstanding = 4'(tag_cnt);
  assign dma_rnw     = rnw[cur];
  assign dma_addr    = addr[int'(cur)*AW +: AW];
  assign dma_wd      = wd[int'(cur)*DW +: DW];

  // dma_req stays up until dma_ack even if the device drops req meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      dma_req <= 1'b0;
      cur     <= '0;
      rr_ptr  <= CW'(NCH - 1);
      err_unf <= 1'b0;
    end else begin
      if (dma_end && !tag_vld) err_unf <= 1'b1;
      case (state)
        S_IDLE: begin
          if (grant) begin
            cur     <= winner;
            rr_ptr  <= winner;
            dma_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (dma_ack) begin
            dma_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_sequencer_n.sv
// Bench for dma_sequencer_n: directed scenarios plus random traffic, checked by a negedge monitor
// against a transaction-level model (tag queue, grant rule, sticky underflow flag).
module tb_dma_sequencer_n;
  localparam int NCH = 4, AW = 21, DW = 8, OUTST = 2, RR = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req, rnw, ack, done;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wd;
  logic [DW-1:0]     rd, dma_wd, dma_rd;
  logic              dma_req, dma_rnw, dma_ack, dma_end, err_unf;
  logic [AW-1:0]     dma_addr;
  logic [3:0]        outstanding;

  dma_sequencer_n #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST), .RR(RR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rnw(rnw), .addr(addr), .wd(wd),
    .ack(ack), .done(done), .rd(rd), .dma_req(dma_req), .dma_rnw(dma_rnw),
    .dma_addr(dma_addr), .dma_wd(dma_wd), .dma_ack(dma_ack), .dma_end(dma_end),
    .dma_rd(dma_rd), .outstanding(outstanding), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int             tagq[$];
  bit             m_req;
  int             m_cur;
  int             m_last;
  bit             m_err;
  int             cnt0;
  logic [NCH-1:0] exp_ack, exp_done;

  // Winner = requester at the smallest circular distance past the last grant (or lowest index).
  function automatic int arb(input logic [NCH-1:0] r, input int last);
    int best = -1;
    int bestd = NCH + 1;
    for (int c = 0; c < NCH; c++) begin
      if (r[c]) begin
        int d;
        d = (RR != 0) ? ((c - last - 1 + 2 * NCH) % NCH) : c;
        if (d < bestd) begin
          bestd = d;
          best = c;
        end
      end
    end
    return best;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_dma_req", dma_req, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_unf", err_unf, 0);
      chk("rst_ack", ack, 0);
      chk("rst_done", done, 0);
      m_req = 0; m_last = NCH - 1; m_err = 0; m_cur = 0;
      tagq.delete();
    end else begin
      cnt0 = tagq.size();
      chk("dma_req", dma_req, m_req);
      chk("outstanding", outstanding, cnt0);
      chk("err_unf", err_unf, m_err);
      exp_ack = '0;
      exp_done = '0;
      if (m_req) begin
        chk("dma_addr", dma_addr, addr[m_cur*AW +: AW]);
        chk("dma_rnw", dma_rnw, rnw[m_cur]);
        chk("dma_wd", dma_wd, wd[m_cur*DW +: DW]);
        if (dma_ack) exp_ack[m_cur] = 1'b1;
      end
      if (dma_end) begin
        if (cnt0 != 0) begin
          exp_done[tagq[0]] = 1'b1;
          chk("rd", rd, dma_rd);
          void'(tagq.pop_front());
        end else begin
          m_err = 1;
        end
      end
      chk("ack", ack, exp_ack);
      chk("done", done, exp_done);
      if (m_req) begin
        if (dma_ack) begin
          tagq.push_back(m_cur);
          m_req = 0;
        end
      end else if (req != 0 && cnt0 < OUTST) begin
        m_cur = arb(req, m_last);
        m_last = m_cur;
        m_req = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [NCH-1:0] ack_s;
  logic [NCH-1:0] ack_log[$];
  int             rr_cnt[NCH];
  int             n;
  logic [AW-1:0]  a3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    ack_s = ack;
  endtask

  task automatic new_req(input int c);
    req[c] = 1'b1;
    rnw[c] = 1'($urandom);
    addr[c*AW +: AW] = AW'($urandom);
    wd[c*DW +: DW] = DW'($urandom);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      at_neg();
      if (dma_req) break;
    end
    chk("wait_dma_req", dma_req, 1);
  endtask

  task automatic cyc(input bit auto_ack, input bit auto_end, input bit keep, input logic [NCH-1:0] clr);
    tick();
    for (int c = 0; c < NCH; c++) begin
      if (clr[c]) req[c] = 1'b0;
      else if (ack_s[c]) begin
        if (keep) new_req(c);
        else req[c] = 1'b0;
      end
    end
    dma_ack = auto_ack && dma_req;
    dma_end = auto_end && (outstanding != 0);
    dma_rd = DW'($urandom);
    at_neg();
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; req = '0; rnw = '0; addr = '0; wd = '0;
    dma_ack = 0; dma_end = 0; dma_rd = '0; ack_s = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // 1: single read on channel 2
    tick();
    req[2] = 1; rnw[2] = 1; addr[2*AW +: AW] = 21'h0A123; wd[2*DW +: DW] = 8'h00;
    wait_req();
    tick(); tick(); tick(); dma_ack = 1;
    at_neg();
    chk("t1_ack", ack, 4'b0100);
    chk("t1_addr", dma_addr, 21'h0A123);
    chk("t1_rnw", dma_rnw, 1);
    tick(); dma_ack = 0; req[2] = 0;
    tick(); tick(); dma_end = 1; dma_rd = 8'h5A;
    at_neg();
    chk("t1_done", done, 4'b0100);
    chk("t1_rd", rd, 8'h5A);
    tick(); dma_end = 0;

    // 2: round-robin fairness, last grant was channel 2
    tick();
    for (int c = 0; c < NCH; c++) begin new_req(c); rr_cnt[c] = 0; end
    at_neg();
    n = 0;
    for (int i = 0; i < 200 && n < 16; i++) begin
      cyc(1, 1, 1, '0);
      if (ack_s != 0) begin
        for (int c = 0; c < NCH; c++)
          if (ack_s[c]) begin
            chk("rr_order", c, (3 + n) % NCH);
            rr_cnt[c]++;
          end
        n++;
      end
    end
    chk("rr_total", n, 16);
    for (int c = 0; c < NCH; c++) chk("rr_share", rr_cnt[c], 4);
    repeat (8) cyc(1, 1, 0, '1);

    // 3: two in flight, third blocked until first end
    tick();
    for (int c = 0; c < 3; c++) new_req(c);
    dma_end = 0;
    at_neg();
    ack_log.delete();
    for (int i = 0; i < 40 && ack_log.size() < 2; i++) begin
      cyc(1, 0, 0, '0);
      if (ack_s != 0) ack_log.push_back(ack_s);
    end
    repeat (5) cyc(1, 0, 0, '0);
    chk("pipe_block_req", dma_req, 0);
    chk("pipe_outstanding", outstanding, 2);
    if (ack_log.size() == 2) begin
      chk("pipe_ack_first", ack_log[0], 4'b0001);
      chk("pipe_ack_second", ack_log[1], 4'b0010);
    end else chk("pipe_ack_count", ack_log.size(), 2);
    tick(); dma_end = 1; dma_rd = 8'h11;
    at_neg();
    chk("pipe_done0", done, 4'b0001);
    chk("pipe_rd0", rd, 8'h11);
    tick(); dma_rd = 8'h22;
    at_neg();
    chk("pipe_done1", done, 4'b0010);
    chk("pipe_rd1", rd, 8'h22);
    tick(); dma_end = 0;

    // 4: same-cycle ack and end with one outstanding
    wait_req();
    tick(); dma_ack = 1;
    at_neg();
    chk("t4_ack_ch2", ack, 4'b0100);
    tick(); dma_ack = 0; req[2] = 0; new_req(3);
    wait_req();
    tick(); dma_ack = 1; dma_end = 1; dma_rd = 8'h33;
    at_neg();
    chk("t4_ack", ack, 4'b1000);
    chk("t4_done", done, 4'b0100);
    tick(); dma_ack = 0; dma_end = 0; req[3] = 0;
    at_neg();
    chk("t4_outstanding", outstanding, 1);
    tick(); dma_end = 1; dma_rd = 8'h44;
    at_neg();
    chk("t4_done_ch3", done, 4'b1000);
    tick(); dma_end = 0;

    // 5: spurious end
    tick(); dma_end = 1;
    at_neg();
    chk("t5_no_done", done, 0);
    tick(); dma_end = 0;
    at_neg();
    chk("t5_err", err_unf, 1);
    tick(); tick(); tick();
    at_neg();
    chk("t5_err_sticky", err_unf, 1);

    // 6: reset while a request is presented and a tag is outstanding
    tick(); new_req(0); new_req(1);
    wait_req();
    tick(); dma_ack = 1;
    at_neg();
    chk("t6_ack_ch0", ack, 4'b0001);
    tick(); dma_ack = 0; req[0] = 0;
    wait_req();
    chk("t6_pre_outstanding", outstanding, 1);
    tick(); rst_n = 0; req[1] = 0;
    #1;
    chk("t6_rst_dma_req", dma_req, 0);
    chk("t6_rst_outstanding", outstanding, 0);
    chk("t6_rst_err", err_unf, 0);
    tick(); tick(); rst_n = 1; new_req(3); a3 = addr[3*AW +: AW];
    wait_req();
    chk("t6_addr", dma_addr, a3);
    tick(); dma_ack = 1;
    at_neg();
    chk("t6_ack", ack, 4'b1000);
    tick(); dma_ack = 0; req[3] = 0;
    tick(); dma_end = 1;
    at_neg();
    chk("t6_done", done, 4'b1000);
    tick(); dma_end = 0;

    // random traffic
    at_neg();
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (ack_s[c]) req[c] = 1'b0;
        else if (!req[c] && $urandom_range(0, 3) == 0) new_req(c);
      end
      dma_ack = dma_req && ($urandom_range(0, 2) != 0);
      dma_end = (outstanding != 0) && ($urandom_range(0, 2) == 0);
      dma_rd = DW'($urandom);
      at_neg();
    end
    repeat (20) cyc(1, 1, 0, '1);
    chk("final_outstanding", outstanding, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
